// File: rtl/hs_mem_pkg.sv
// Shared definitions for the handshake memory: access-size encodings, FSM state type
// and the byte-lane mask helper.
package hs_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Lanes touched by an access of the given size, relative to its base address.
    function automatic logic [3:0] laneMask(input logic [1:0] size);
        case (size)
            SZ_BYTE: laneMask = 4'b0001;
            SZ_HALF: laneMask = 4'b0011;
            SZ_WORD: laneMask = 4'b1111;
            default: laneMask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/hs_mem_array.sv
// Byte-organised storage with per-lane write enables and a 4-byte little-endian read port.
// Lane k maps to baseAddr_i+k, wrapping modulo the array size; contents have no reset.
module hs_mem_array
    import hs_mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic [3:0]        byteEn_i,
    input  logic [ADDR_W-1:0] baseAddr_i,
    input  logic [31:0]       wrData_i,
    output logic [31:0]       rdData_o
);

    logic [7:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            if (byteEn_i[k]) begin
                mem_q[baseAddr_i + ADDR_W'(k)] <= wrData_i[8*k +: 8];
            end
        end
    end

    always_comb begin
        rdData_o = '0;
        for (int k = 0; k < 4; k++) begin
            rdData_o[8*k +: 8] = mem_q[baseAddr_i + ADDR_W'(k)];
        end
    end

endmodule

// File: rtl/hs_memory.sv
// Four-phase MFA/MFC memory with a programmable wait-state count.
// Define HS_MEMORY_ALIGN_CHECK_EN to fault misaligned accesses instead of force-aligning them.
module hs_memory
    import hs_mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2,
    parameter int DATA_W      = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MFA,
    input  logic              READ_WRITE,
    input  logic [1:0]        SIZE,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              MFC,
    output logic              ERR
);

    state_t              state_q, state_d;
    logic [3:0]          count_q, count_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                read_q, read_d;
    logic [DATA_W-1:0]   wrData_q, wrData_d;
    logic [DATA_W-1:0]   dataOut_q, dataOut_d;
    logic                mfc_q, mfc_d;
    logic                err_q, err_d;

    logic [ADDR_W-1:0]   effAddr;
    logic                fault;
    logic                execute;
    logic [3:0]          byteEn;
    logic [DATA_W-1:0]   rdData;
    logic [DATA_W-1:0]   rdExt;

    // Address alignment and fault decode for the captured request.
    always_comb begin
        effAddr = addr_q;
        if (size_q == SZ_HALF) begin
            effAddr[0] = 1'b0;
        end else if (size_q == SZ_WORD) begin
            effAddr[1:0] = 2'b00;
        end
`ifdef HS_MEMORY_ALIGN_CHECK_EN
        fault = (size_q == SZ_RSVD)
              || (size_q == SZ_HALF && addr_q[0])
              || (size_q == SZ_WORD && addr_q[1:0] != 2'b00);
`else
        fault = (size_q == SZ_RSVD);
`endif
        execute = (state_q == ST_WAIT) && (count_q == 4'd0);
        // Reset on the execute edge must also suppress the write.
        byteEn = (execute && !read_q && !fault && !Reset) ? laneMask(size_q) : 4'b0000;
        case (size_q)
            SZ_BYTE: rdExt = {24'b0, rdData[7:0]};
            SZ_HALF: rdExt = {16'b0, rdData[15:0]};
            default: rdExt = rdData;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        addr_d    = addr_q;
        size_d    = size_q;
        read_d    = read_q;
        wrData_d  = wrData_q;
        dataOut_d = dataOut_q;
        mfc_d     = mfc_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (MFA) begin
                    addr_d   = Address;
                    size_d   = SIZE;
                    read_d   = READ_WRITE;
                    wrData_d = DataIn;
                    count_d  = 4'(WAIT_STATES);
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    state_d = ST_DONE;
                    mfc_d   = 1'b1;
                    err_d   = fault;
                    if (read_q && !fault) begin
                        dataOut_d = rdExt;
                    end
                end
            end
            ST_DONE: begin
                if (!MFA) begin
                    mfc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            count_q   <= 4'd0;
            addr_q    <= '0;
            size_q    <= SZ_BYTE;
            read_q    <= 1'b0;
            wrData_q  <= '0;
            dataOut_q <= '0;
            mfc_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            read_q    <= read_d;
            wrData_q  <= wrData_d;
            dataOut_q <= dataOut_d;
            mfc_q     <= mfc_d;
            err_q     <= err_d;
        end
    end

    hs_mem_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk_i      (Clk),
        .byteEn_i   (byteEn),
        .baseAddr_i (effAddr),
        .wrData_i   (wrData_q),
        .rdData_o   (rdData)
    );

    assign DataOut = dataOut_q;
    assign MFC     = mfc_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_hs_memory.sv
// Scoreboard bench for hs_memory: randomized accesses against a byte-array reference model,
// plus a small zero-wait-state instance with a 16-byte array.
module tb_hs_memory;
    import hs_mem_pkg::*;

    localparam int WS = 2;

    logic        Clk;
    logic        Reset;
    logic        MFA, READ_WRITE;
    logic [1:0]  SIZE;
    logic [7:0]  Address;
    logic [31:0] DataIn, DataOut;
    logic        MFC, ERR;

    logic        MFA0, READ_WRITE0;
    logic [1:0]  SIZE0;
    logic [3:0]  Address0;
    logic [31:0] DataIn0, DataOut0;
    logic        MFC0, ERR0;

    hs_memory #(.ADDR_W(8), .WAIT_STATES(WS), .DATA_W(32)) dut (
        .Clk(Clk), .Reset(Reset), .MFA(MFA), .READ_WRITE(READ_WRITE), .SIZE(SIZE),
        .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MFC(MFC), .ERR(ERR)
    );

    hs_memory #(.ADDR_W(4), .WAIT_STATES(0), .DATA_W(32)) dut0 (
        .Clk(Clk), .Reset(Reset), .MFA(MFA0), .READ_WRITE(READ_WRITE0), .SIZE(SIZE0),
        .Address(Address0), .DataIn(DataIn0), .DataOut(DataOut0), .MFC(MFC0), .ERR(ERR0)
    );

    typedef struct {
        int          edgeNo;
        logic        err;
        logic [31:0] dout;
    } exp_t;

    exp_t        sbQ[$];
    exp_t        item;
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    logic        prevMfc = 1'b0;
    logic [7:0]  memModel [256];
    logic [31:0] expDout = '0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc++;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // Behavioural model: an access is a list of n bytes starting at an n-aligned base.
    function automatic void modelAccess(input bit rw, input logic [1:0] sz, input logic [7:0] addr,
                                        input logic [31:0] data, output logic err, output logic [31:0] dout);
        int n, base;
        logic [31:0] val;
        n   = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
        err = (sz == SZ_RSVD);
`ifdef HS_MEMORY_ALIGN_CHECK_EN
        if (!err && (int'(addr) % n) != 0) err = 1'b1;
`endif
        base = int'(addr) - int'(addr) % n;
        if (!err) begin
            if (rw) begin
                val = '0;
                for (int k = 0; k < n; k++) val |= 32'(memModel[(base + k) % 256]) << (8 * k);
                expDout = val;
            end else begin
                for (int k = 0; k < n; k++) memModel[(base + k) % 256] = data[8*k +: 8];
            end
        end
        dout = expDout;
    endfunction

    // Called and returns at a falling edge; DUT is idle on entry and exit.
    task automatic applyStimulus(input bit rw, input logic [1:0] sz, input logic [7:0] addr,
                                 input logic [31:0] data, input int hold, input bit dropEarly);
        exp_t e;
        int   waitCnt;
        MFA        = 1'b1;
        READ_WRITE = rw;
        SIZE       = sz;
        Address    = addr;
        DataIn     = data;
        modelAccess(rw, sz, addr, data, e.err, e.dout);
        e.edgeNo = cyc + 1 + WS + 1;
        sbQ.push_back(e);
        @(negedge Clk);
        READ_WRITE = 1'($urandom);
        SIZE       = 2'($urandom);
        Address    = 8'($urandom);
        DataIn     = $urandom;
        if (dropEarly) MFA = 1'b0;
        waitCnt = 0;
        while (!MFC && waitCnt < 40) begin
            @(negedge Clk);
            waitCnt++;
        end
        if (!MFC) begin
            checkOutput("mfcTimeout", MFC, 1'b1);
            MFA = 1'b0;
            @(negedge Clk);
            return;
        end
        if (dropEarly) begin
            @(negedge Clk);
            checkOutput("mfcPulse", MFC, 1'b0);
            return;
        end
        repeat (hold) begin
            @(negedge Clk);
            checkOutput("mfcHold", MFC, 1'b1);
        end
        MFA = 1'b0;
        @(negedge Clk);
        checkOutput("mfcFall", MFC, 1'b0);
        checkOutput("errFall", ERR, 1'b0);
    endtask

    // Scoreboard monitor: each MFC rising edge retires the oldest expected response.
    always @(negedge Clk) begin
        if (MFC && !prevMfc) begin
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedMfc", MFC, 1'b0);
            end else begin
                item = sbQ.pop_front();
                checkOutput("riseEdge", cyc, item.edgeNo);
                checkOutput("err", ERR, item.err);
                checkOutput("dataOut", DataOut, item.dout);
            end
        end
        prevMfc = MFC;
    end

    task automatic run0(input bit rw, input logic [1:0] sz, input logic [3:0] addr, input logic [31:0] din,
                        input logic expErr, input logic [31:0] expD, input string tag);
        MFA0 = 1'b1; READ_WRITE0 = rw; SIZE0 = sz; Address0 = addr; DataIn0 = din;
        @(negedge Clk);
        checkOutput({tag, "_mfcEdge1"}, MFC0, 1'b0);
        @(negedge Clk);
        checkOutput({tag, "_mfcEdge2"}, MFC0, 1'b1);
        checkOutput({tag, "_err"}, ERR0, expErr);
        checkOutput({tag, "_dataOut"}, DataOut0, expD);
        MFA0 = 1'b0;
        @(negedge Clk);
        checkOutput({tag, "_mfcFall"}, MFC0, 1'b0);
    endtask

    initial begin
        Reset = 1'b1; MFA = 1'b0; READ_WRITE = 1'b0; SIZE = SZ_BYTE; Address = '0; DataIn = '0;
        MFA0 = 1'b0; READ_WRITE0 = 1'b0; SIZE0 = SZ_BYTE; Address0 = '0; DataIn0 = '0;
        repeat (3) @(negedge Clk);
        checkOutput("rstMfc", MFC, 1'b0);
        checkOutput("rstErr", ERR, 1'b0);
        checkOutput("rstDataOut", DataOut, 32'h0);
        checkOutput("rstMfc0", MFC0, 1'b0);
        Reset = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < 64; i++) applyStimulus(1'b0, SZ_WORD, 8'(i * 4), $urandom, 0, 1'b0);

        applyStimulus(1'b0, SZ_WORD, 8'h10, 32'hDEADBEEF, 0, 1'b0);
        applyStimulus(1'b1, SZ_WORD, 8'h10, 32'h0, 0, 1'b0);
        checkOutput("readDeadbeef", DataOut, 32'hDEADBEEF);
        applyStimulus(1'b0, SZ_BYTE, 8'h11, 32'h0000005A, 0, 1'b0);
        applyStimulus(1'b1, SZ_WORD, 8'h10, 32'h0, 3, 1'b0);
        checkOutput("readPatched", DataOut, 32'hDEAD5AEF);
        applyStimulus(1'b1, SZ_BYTE, 8'h11, 32'h0, 0, 1'b0);
        checkOutput("readByte", DataOut, 32'h0000005A);
        applyStimulus(1'b1, SZ_HALF, 8'h13, 32'h0, 1, 1'b0);
`ifdef HS_MEMORY_ALIGN_CHECK_EN
        checkOutput("halfOdd", DataOut, 32'h0000005A);
`else
        checkOutput("halfOdd", DataOut, 32'h0000DEAD);
`endif

        // Reset lands on the execute edge of a write, which must then never happen.
        MFA = 1'b1; READ_WRITE = 1'b0; SIZE = SZ_WORD; Address = 8'h20; DataIn = 32'h12345678;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        MFA   = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        expDout = '0;
        repeat (6) @(negedge Clk);
        checkOutput("abortMfc", MFC, 1'b0);
        checkOutput("abortDataOut", DataOut, 32'h0);
        applyStimulus(1'b1, SZ_WORD, 8'h20, 32'h0, 0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom), 2'($urandom_range(0, 3)), 8'($urandom), $urandom,
                          int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
        end
        repeat (4) @(negedge Clk);
        checkOutput("sbEmpty", sbQ.size(), 32'd0);

        run0(1'b0, SZ_WORD, 4'h0, 32'hCAFEF00D, 1'b0, 32'h0, "w0");
        run0(1'b1, SZ_WORD, 4'h0, 32'h0, 1'b0, 32'hCAFEF00D, "r0");
        run0(1'b1, SZ_RSVD, 4'h0, 32'h0, 1'b1, 32'hCAFEF00D, "rsvdRd0");
        run0(1'b0, SZ_RSVD, 4'h0, 32'h12345678, 1'b1, 32'hCAFEF00D, "rsvdWr0");
        run0(1'b1, SZ_WORD, 4'h0, 32'h0, 1'b0, 32'hCAFEF00D, "reread0");
        run0(1'b1, SZ_HALF, 4'h2, 32'h0, 1'b0, 32'h0000CAFE, "half0");
        run0(1'b1, SZ_BYTE, 4'h3, 32'h0, 1'b0, 32'h000000CA, "byte0");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hs_memory.md
HS_MEMORY -- requirements
Module: hs_memory

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width; the array holds 2**ADDR_W bytes.
REQ-002 Parameter WAIT_STATES, default 2, range 0..15, extra cycles inserted before MFC asserts.
REQ-003 Parameter DATA_W, fixed at 32, data bus width.
REQ-004 Port Clk  in  1  single clock; all state changes occur on its rising edge.
REQ-005 Port Reset  in  1  synchronous, active-high reset.
REQ-006 Port MFA  in  1  memory-function-activate request from the CPU.
REQ-007 Port READ_WRITE  in  1  1=read, 0=write.
REQ-008 Port SIZE  in  2  access size: 00=byte, 01=halfword, 10=word, 11=reserved.
REQ-009 Port Address  in  ADDR_W  byte address.
REQ-010 Port DataIn  in  32  write data, right-aligned.
REQ-011 Port DataOut  out  32  read data, right-aligned and zero-extended.
REQ-012 Port MFC  out  1  memory-function-complete.
REQ-013 Port ERR  out  1  access fault, valid only while MFC=1.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, DONE.
REQ-015 In IDLE, MFA=1 at an edge SHALL capture Address, SIZE, READ_WRITE and DataIn, load the wait counter with WAIT_STATES, and go to WAIT.
REQ-016 In WAIT with counter>0, the counter SHALL decrement by 1 per edge.
REQ-017 In WAIT with counter=0, the access SHALL execute and the FSM SHALL go to DONE with MFC=1.
REQ-018 MFC SHALL rise on edge WAIT_STATES+2, counting the capture edge as edge 1.
REQ-019 Storage SHALL be little-endian: byte k of the bus maps to address base+k.
REQ-020 A read SHALL update DataOut on the same edge MFC rises; byte reads return bits 7:0, halfword reads bits 15:0, upper bits 0.
REQ-021 A write SHALL modify only the 1, 2 or 4 addressed bytes; DataOut SHALL be unchanged.
REQ-022 Handshake is four-phase: MFC SHALL stay 1 while MFA=1 in DONE.
REQ-023 When MFA=0 in DONE, MFC and ERR SHALL clear on the next edge and the FSM SHALL return to IDLE.
REQ-024 A new request SHALL be accepted no earlier than one edge after MFC falls.
REQ-025 Changes on MFA, Address, SIZE, READ_WRITE or DataIn during WAIT or DONE SHALL be ignored.
REQ-026 MFA dropped during WAIT SHALL NOT abort the access; MFC SHALL pulse for exactly one cycle.
REQ-027 SIZE=11 SHALL complete with ERR=1, perform no write, and leave DataOut unchanged.
REQ-028 Multi-byte accesses reaching the top address SHALL wrap modulo 2**ADDR_W.

Reset
REQ-029 Reset=1 at an edge SHALL force IDLE, MFC=0, ERR=0, DataOut=0 and counter=0.
REQ-030 Reset SHALL have priority over every other input.
REQ-031 Reset during WAIT or DONE SHALL abandon the access; a pending write SHALL NOT occur.
REQ-032 Array contents SHALL NOT be cleared by Reset.

Configuration
REQ-033 With macro HS_MEMORY_ALIGN_CHECK_EN defined, a halfword at an odd address or a word at Address[1:0]!=0 SHALL complete with ERR=1, perform no write, and leave DataOut unchanged.
REQ-034 Without HS_MEMORY_ALIGN_CHECK_EN, misaligned addresses SHALL be force-aligned by clearing the low bits; ERR SHALL assert only for SIZE=11.

Structure
REQ-035 A shared package hs_mem_pkg SHALL hold the SIZE encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD) and the FSM state typedef.
REQ-036 The byte array SHALL be a sub-module hs_mem_array: byte-lane write enables and a 4-byte little-endian read port.
REQ-037 The FSM, wait counter and alignment logic SHALL reside in hs_memory.

Verification
REQ-038 WAIT_STATES=2: word write 0xDEADBEEF @0x10, then word read @0x10 -> DataOut=0xDEADBEEF; MFC rises on edge 4 of each access.
REQ-039 Byte write 0x5A @0x11 over 0xDEADBEEF, then word read @0x10 -> 0xDEAD5AEF; byte read @0x11 -> 0x0000005A.
REQ-040 MFA held 3 cycles past MFC -> MFC stays 1 throughout; MFA=0 -> MFC=0 on the next edge; a back-to-back request is accepted on the following edge.
REQ-041 Halfword read @0x13 -> with the macro, ERR=1 and DataOut unchanged; without it, DataOut=0x0000DEAD, the halfword at 0x12.
REQ-042 Reset pulsed during WAIT of a write 0x12345678 @0x20 -> MFC never rises; a subsequent read @0x20 returns the prior contents.
REQ-043 WAIT_STATES=0, ADDR_W=4: word write @0x0 -> MFC rises on edge 2; SIZE=11 -> ERR=1 and MFC=1.
